// File: rtl/cpu16_pkg.sv
// Shared CPU16 definitions: instruction width, opcode map, fetch state and
// buffer entry types, and the legal-opcode check used by fetch and control.
package cpu16_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0] OP_LOGIC = 4'b0000;
  localparam logic [3:0] OP_ARITH = 4'b0001;
  localparam logic [3:0] OP_SHIFT = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_SLTI  = 4'b1011;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_BEQ   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic isLegalOp(input logic [3:0] op);
    case (op)
      OP_LOGIC, OP_ARITH, OP_SHIFT,
      OP_ADDI, OP_SUBI, OP_SLTI,
      OP_LW, OP_SW, OP_BEQ: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Small circular FIFO of {instr, pc} entries with synchronous clear; the head
// entry is read straight from the storage registers.
module fetch_buffer
  import cpu16_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           Clear,
  input  logic                           Push,
  input  logic                           Pop,
  input  fetch_entry_t                   WrData,
  output fetch_entry_t                   RdData,
  output logic                           Empty,
  output logic                           Full,
  output logic [$clog2(BUF_DEPTH+1)-1:0] Count
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_entry_t     slots [BUF_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign Empty  = (Count == '0);
  assign Full   = (Count == CNT_W'(BUF_DEPTH));
  assign doPop  = Pop && !Empty;
  assign doPush = Push && (!Full || doPop);
  assign RdData = slots[rdPtr];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) slots[i] <= '0;
    end else if (Clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      if (doPush) begin
        slots[wrPtr] <= WrData;
        wrPtr        <= nextPtr(wrPtr);
      end
      if (doPop) rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   Count <= Count + CNT_W'(1);
        2'b01:   Count <= Count - CNT_W'(1);
        default: Count <= Count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// CPU16 instruction fetch front end: credit-limited in-order requests to
// instruction memory, buffered responses, redirect flush and decode of opcode.
module instr_fetch_unit
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [15:0] ImemReqAddr,
  input  logic        ImemRspValid,
  input  logic [15:0] ImemRspData,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  output logic        InstrValid,
  output logic [15:0] Instr,
  output logic [15:0] InstrPC,
  output logic [3:0]  Opcode,
  output logic        IllegalOp
);

  localparam int unsigned CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam logic [15:0] START_PC = RESET_PC & 16'hFFFE;

  fetch_state_e      state;
  logic [15:0]       pc;
  logic [CNT_W-1:0]  dropCnt;

  fetch_entry_t      bufHead;
  fetch_entry_t      tagHead;
  fetch_entry_t      tagEntry;
  fetch_entry_t      pushEntry;
  logic              bufEmpty;
  logic              bufFull;
  logic              tagEmpty;
  logic              tagFull;
  logic [CNT_W-1:0]  bufCount;
  logic [CNT_W-1:0]  tagCount;

  logic              creditOk;
  logic              reqFire;
  logic              rspFire;
  logic              keepRsp;
  logic              popHead;
  logic              flushBuf;
  logic [CNT_W-1:0]  outAfter;
  logic [15:0]       redirectTarget;

  // The tag FIFO is pushed per accepted request and popped per response, so
  // its occupancy is the outstanding count in every state.
  assign creditOk       = (32'(tagCount) + 32'(bufCount)) < BUF_DEPTH;
  assign ImemReqValid   = (state == RUN) && creditOk && !Redirect && !tagFull;
  assign ImemReqAddr    = pc;
  assign reqFire        = ImemReqValid && ImemReqReady;
  assign rspFire        = ImemRspValid && !tagEmpty && (state != IDLE);
  assign keepRsp        = rspFire && (state == RUN) && !Redirect && !bufFull;
  assign popHead        = !bufEmpty && !Stall && !Redirect;
  assign flushBuf       = Redirect && (state != IDLE);
  assign outAfter       = tagCount - CNT_W'(rspFire);
  assign redirectTarget = RedirectPC & 16'hFFFE;

  assign tagEntry = '{instr: '0, pc: pc};

  always_comb begin
    pushEntry       = tagHead;
    pushEntry.instr = ImemRspData;
  end

  fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_tagFifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .Clear  (1'b0),
    .Push   (reqFire),
    .Pop    (rspFire),
    .WrData (tagEntry),
    .RdData (tagHead),
    .Empty  (tagEmpty),
    .Full   (tagFull),
    .Count  (tagCount)
  );

  fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_instrBuf (
    .Clock  (Clock),
    .Reset  (Reset),
    .Clear  (flushBuf),
    .Push   (keepRsp),
    .Pop    (popHead),
    .WrData (pushEntry),
    .RdData (bufHead),
    .Empty  (bufEmpty),
    .Full   (bufFull),
    .Count  (bufCount)
  );

  assign InstrValid = !bufEmpty;
  assign Instr      = bufHead.instr;
  assign InstrPC    = bufHead.pc;
  assign Opcode     = bufHead.instr[15:12];
  assign IllegalOp  = InstrValid && !isLegalOp(bufHead.instr[15:12]);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      pc      <= START_PC;
      dropCnt <= '0;
    end else begin
      unique case (state)
        IDLE: state <= RUN;
        RUN, FLUSH: begin
          if (Redirect) begin
            pc      <= redirectTarget;
            dropCnt <= outAfter;
            state   <= (outAfter != '0) ? FLUSH : RUN;
          end else if (state == RUN) begin
            if (reqFire) pc <= pc + 16'd2;
          end else if (dropCnt == '0) begin
            state <= RUN;
          end else if (rspFire) begin
            dropCnt <= dropCnt - CNT_W'(1);
            if (dropCnt == CNT_W'(1)) state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus randomized traffic checked
// against a queue-based model of the fetch rules and an in-bench memory.
module tb_instr_fetch_unit;

  localparam logic [15:0] MODEL_RESET_PC = 16'h0000;
  localparam logic [15:0] LEGAL_MASK     = 16'b1011_1110_0000_0111;

  logic        Clock;
  logic        Reset;
  logic        ImemReqValid, ImemReqReady, ImemRspValid;
  logic [15:0] ImemReqAddr, ImemRspData;
  logic        Stall, Redirect;
  logic [15:0] RedirectPC;
  logic        InstrValid, IllegalOp;
  logic [15:0] Instr, InstrPC;
  logic [3:0]  Opcode;

  logic        wReqValid, wRspValid, wInstrValid, wIllegalOp;
  logic [15:0] wReqAddr, wInstr, wInstrPC;
  logic [3:0]  wOpcode;

  instr_fetch_unit u_dut (
    .Clock(Clock), .Reset(Reset),
    .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemReqAddr(ImemReqAddr),
    .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC),
    .Opcode(Opcode), .IllegalOp(IllegalOp)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFC)) u_wrap (
    .Clock(Clock), .Reset(Reset),
    .ImemReqValid(wReqValid), .ImemReqReady(1'b1), .ImemReqAddr(wReqAddr),
    .ImemRspValid(wRspValid), .ImemRspData(16'h1000),
    .Stall(1'b0), .Redirect(1'b0), .RedirectPC(16'h0000),
    .InstrValid(wInstrValid), .Instr(wInstr), .InstrPC(wInstrPC),
    .Opcode(wOpcode), .IllegalOp(wIllegalOp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct { logic [15:0] pc; bit live; int due; } req_t;
  typedef struct { logic [15:0] instr; logic [15:0] pc; } ent_t;

  req_t        tags[$];
  ent_t        fifo[$];
  bit          mIdle;
  logic [15:0] mPC;
  bit          justReset;
  int          cyc;
  logic [15:0] mem [0:32767];

  int          pReady, latMin, latMax, pRsp, pStall, pRedir;
  bit          forceRedir, forceSpur;
  logic [15:0] forceTarget;

  int          checks, errors;
  int          wPend;
  logic [15:0] wAddrs[$];

  logic        obsValid, obsIll, obsReq;
  logic [15:0] obsPC;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mRun();
    if (mIdle) return 1'b0;
    foreach (tags[i]) if (!tags[i].live) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycle();
    bit          expReq, gotReq, wSeen, rspOk, pop, redir;
    logic [15:0] a;
    ent_t        e;
    req_t        r;
    Stall        = ($urandom_range(99) < pStall);
    ImemReqReady = ($urandom_range(99) < pReady);
    Redirect     = forceRedir || ($urandom_range(99) < pRedir);
    RedirectPC   = forceRedir ? forceTarget : 16'($urandom);
    if (forceSpur) begin
      ImemRspValid = 1'b1;
      ImemRspData  = 16'($urandom);
    end else if (tags.size() > 0 && tags[0].due <= cyc && $urandom_range(99) < pRsp) begin
      a            = tags[0].pc;
      ImemRspValid = 1'b1;
      ImemRspData  = mem[a[15:1]];
    end else begin
      ImemRspValid = 1'b0;
      ImemRspData  = 16'($urandom);
    end
    wRspValid = (wPend > 0);

    @(negedge Clock);
    expReq = mRun() && (tags.size() + fifo.size() < 2) && !Redirect;
    chk("reqValid", ImemReqValid, expReq);
    chk("reqAddr", ImemReqAddr, mPC);
    chk("instrValid", InstrValid, fifo.size() > 0);
    if (fifo.size() > 0) begin
      e = fifo[0];
      chk("instr", Instr, e.instr);
      chk("instrPC", InstrPC, e.pc);
      chk("opcode", Opcode, e.instr / 4096);
      chk("illegalOp", IllegalOp, !LEGAL_MASK[e.instr / 4096]);
    end
    if (justReset) begin
      chk("rstInstr", Instr, 0);
      chk("rstInstrPC", InstrPC, 0);
      chk("rstOpcode", Opcode, 0);
      chk("rstIllegal", IllegalOp, 0);
    end
    obsValid = InstrValid; obsPC = InstrPC; obsIll = IllegalOp; obsReq = ImemReqValid;
    gotReq = expReq && ImemReqReady;
    wSeen  = wReqValid;
    if (!Reset && wReqValid && wAddrs.size() < 3) wAddrs.push_back(wReqAddr);

    @(posedge Clock);
    if (Reset) begin
      mIdle = 1'b1; mPC = MODEL_RESET_PC; tags.delete(); fifo.delete();
      justReset = 1'b1; wPend = 0;
    end else begin
      justReset = 1'b0;
      rspOk = ImemRspValid && !mIdle && tags.size() > 0;
      pop   = fifo.size() > 0 && !Stall && !Redirect;
      redir = Redirect && !mIdle;
      if (pop) void'(fifo.pop_front());
      if (rspOk) begin
        r = tags.pop_front();
        if (r.live && !redir) begin
          e.instr = ImemRspData; e.pc = r.pc;
          fifo.push_back(e);
        end
      end
      if (redir) begin
        fifo.delete();
        foreach (tags[i]) tags[i].live = 1'b0;
        mPC = RedirectPC & 16'hFFFE;
      end else if (gotReq) begin
        r.pc = mPC; r.live = 1'b1; r.due = cyc + int'($urandom_range(latMax, latMin));
        tags.push_back(r);
        mPC = mPC + 16'd2;
      end
      mIdle = 1'b0;
      wPend = wPend + int'(wSeen) - int'(wRspValid);
    end
    cyc++;
    #1;
  endtask

  initial begin
    int          firstValid;
    int          n;
    logic [15:0] seen[$];
    logic        ill6, ill8;
    checks = 0; errors = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1123; mem[1] = 16'h9405; mem[2] = 16'hC208;
    mem[3] = 16'h5ABC; mem[4] = 16'hF0FF;
    pReady = 100; latMin = 1; latMax = 1; pRsp = 100; pStall = 0; pRedir = 0;
    forceRedir = 0; forceSpur = 0; forceTarget = 16'h0;
    mIdle = 1; mPC = MODEL_RESET_PC; justReset = 1; cyc = 0; wPend = 0;
    Reset = 1; Stall = 0; Redirect = 0; RedirectPC = 0;
    ImemReqReady = 0; ImemRspValid = 0; ImemRspData = 0; wRspValid = 0;
    @(posedge Clock); #1;
    chk("wrapRstAddr", wReqAddr, 16'hFFFC);
    chk("wrapRstValid", wInstrValid, 0);
    chk("wrapRstInstr", wInstr, 0);
    chk("wrapRstPC", wInstrPC, 0);
    chk("wrapRstOp", {wOpcode, wIllegalOp}, 0);
    cycle(); cycle();

    // basic fetch, including a spurious response while idle
    Reset = 0; cyc = 0;
    forceSpur = 1; cycle(); forceSpur = 0;
    firstValid = -1; ill6 = 1'bx; ill8 = 1'bx;
    for (int i = 1; i < 20; i++) begin
      cycle();
      if (obsValid) begin
        if (firstValid < 0) firstValid = i;
        seen.push_back(obsPC);
        if (obsPC == 16'h0006) ill6 = obsIll;
        if (obsPC == 16'h0008) ill8 = obsIll;
      end
    end
    chk("firstValidCycle", firstValid, 3);
    chk("seqCount", seen.size() >= 3, 1);
    if (seen.size() >= 3) begin
      chk("seqPC0", seen[0], 16'h0000);
      chk("seqPC1", seen[1], 16'h0002);
      chk("seqPC2", seen[2], 16'h0004);
    end
    chk("illegal5ABC", ill6, 1);
    chk("legalF0FF", ill8, 0);
    chk("wrapCount", wAddrs.size(), 3);
    if (wAddrs.size() == 3) begin
      chk("wrapAddr0", wAddrs[0], 16'hFFFC);
      chk("wrapAddr1", wAddrs[1], 16'hFFFE);
      chk("wrapAddr2", wAddrs[2], 16'h0000);
    end

    // stall until credits run out, then release
    pStall = 100;
    for (int i = 0; i < 5; i++) cycle();
    chk("stallCreditLow", obsReq, 0);
    pStall = 0;
    for (int i = 0; i < 10; i++) cycle();

    // redirect with two requests in flight
    latMin = 3; latMax = 3;
    n = 0;
    while (tags.size() != 2 && n < 30) begin cycle(); n++; end
    chk("waitTwoOutstanding", tags.size(), 2);
    forceRedir = 1; forceTarget = 16'h0041; cycle(); forceRedir = 0;
    latMin = 1; latMax = 1;
    n = 0; obsValid = 0;
    while (!obsValid && n < 30) begin cycle(); n++; end
    chk("redirFirstValid", obsValid, 1);
    chk("redirFirstPC", obsPC, 16'h0040);

    // randomized traffic
    pReady = 70; latMin = 1; latMax = 3; pRsp = 80; pStall = 30; pRedir = 3;
    for (int i = 0; i < 1500; i++) cycle();

    // reset while busy
    pReady = 100; latMin = 2; latMax = 3; pStall = 60; pRedir = 0;
    n = 0;
    while (!(tags.size() + fifo.size() == 2 && tags.size() > 0) && n < 50) begin cycle(); n++; end
    chk("waitBusy", tags.size() + fifo.size(), 2);
    Reset = 1; cycle(); Reset = 0;
    cycle();
    pReady = 80; latMin = 1; latMax = 2; pStall = 20; pRedir = 2;
    for (int i = 0; i < 300; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
